// File: rtl/conv1_sched_ctrl.sv
// conv1_sched_ctrl: conv1 sequencer. Loads the filter weight matrix, slides a
// row window down the frame and issues one MAC-array convolution per window.
// Ports:
//   clk_i, rst_i                      clock, sync active-high reset
//   start_i, wght_reload_i            frame start and forced weight reload
//   wght_vld_i/wght_data_i/wght_rdy_o weight word stream
//   row_vld_i/row_data_i/row_rdy_o    image row stream
//   wght_matx_o, row_win_o            registered operands to the routing block
//   conv_start_o, conv_done_i         MAC-array handshake
//   conv_row_o                        top-row index of the current window
//   busy_o, frame_done_o              status
module conv1_sched_ctrl #(
  parameter int NUM_FILT          = 6,
  parameter int FILT_INST         = 4,
  parameter int NUM_FILT_ROWS     = 5,
  parameter int WEIGHT_WIDTH_BYTE = 40,
  parameter int DATA_WIDTH        = 64,
  parameter int ROWS_PER_FRAME    = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         wght_reload_i,
  input  logic                         wght_vld_i,
  input  logic [WEIGHT_WIDTH_BYTE-1:0] wght_data_i,
  output logic                         wght_rdy_o,
  input  logic                         row_vld_i,
  input  logic [DATA_WIDTH-1:0]        row_data_i,
  output logic                         row_rdy_o,
  output logic [NUM_FILT*FILT_INST-1:0][NUM_FILT_ROWS-1:0]
               [WEIGHT_WIDTH_BYTE-1:0] wght_matx_o,
  output logic [NUM_FILT_ROWS-1:0][DATA_WIDTH-1:0] row_win_o,
  output logic                         conv_start_o,
  input  logic                         conv_done_i,
  output logic [$clog2(ROWS_PER_FRAME)-1:0] conv_row_o,
  output logic                         busy_o,
  output logic                         frame_done_o
);

  localparam int NF  = NUM_FILT * FILT_INST;
  localparam int NW  = NF * NUM_FILT_ROWS;
  localparam int WCW = $clog2(NW);
  localparam int FW  = (NF > 1) ? $clog2(NF) : 1;
  localparam int RW  = (NUM_FILT_ROWS > 1) ? $clog2(NUM_FILT_ROWS) : 1;
  localparam int RCW = $clog2(ROWS_PER_FRAME + 1);
  localparam int CRW = $clog2(ROWS_PER_FRAME);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROW,
    S_CONV,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic                 loaded_q;
  logic [WCW-1:0]       wght_cnt_q;
  logic [FW-1:0]        fi_q;
  logic [RW-1:0]        ri_q;
  logic [RCW-1:0]       row_cnt_q;
  logic                 conv_first_q;
  logic [NF-1:0][NUM_FILT_ROWS-1:0][WEIGHT_WIDTH_BYTE-1:0] matx_q;
  logic [NUM_FILT_ROWS-1:0][DATA_WIDTH-1:0] win_q;

  logic           start_acc;
  logic           wght_acc;
  logic           wght_last;
  logic           row_acc;
  logic [RCW-1:0] row_cnt_inc;
  logic [RCW-1:0] top_row;
  logic           frame_end;

  // Handshakes qualify on state only, so ready never depends on valid.
  assign start_acc   = (state_q == S_IDLE) && start_i;
  assign wght_acc    = (state_q == S_LOAD) && wght_vld_i;
  assign wght_last   = wght_cnt_q == WCW'(NW - 1);
  assign row_acc     = (state_q == S_ROW) && row_vld_i;
  assign row_cnt_inc = row_cnt_q + RCW'(1);
  assign top_row     = row_cnt_q - RCW'(NUM_FILT_ROWS);
  assign frame_end   = row_cnt_q == RCW'(ROWS_PER_FRAME);

  assign wght_matx_o = matx_q;
  assign row_win_o   = win_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (wght_reload_i || !loaded_q) state_d = S_LOAD;
          else                            state_d = S_ROW;
        end
      end
      S_LOAD: begin
        if (wght_acc && wght_last) state_d = S_ROW;
      end
      S_ROW: begin
        if (row_acc && (row_cnt_inc >= RCW'(NUM_FILT_ROWS)))
          state_d = S_CONV;
      end
      S_CONV: begin
        // A done coinciding with the start pulse belongs to no request.
        if (!conv_first_q && conv_done_i)
          state_d = frame_end ? S_DONE : S_ROW;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wght_rdy_o   = 1'b0;
    row_rdy_o    = 1'b0;
    conv_start_o = 1'b0;
    frame_done_o = 1'b0;
    busy_o       = 1'b1;
    conv_row_o   = '0;
    unique case (state_q)
      S_IDLE: busy_o = 1'b0;
      S_LOAD: wght_rdy_o = 1'b1;
      S_ROW:  row_rdy_o = 1'b1;
      S_CONV: begin
        conv_start_o = conv_first_q;
        conv_row_o   = top_row[CRW-1:0];
      end
      S_DONE:  frame_done_o = 1'b1;
      default: busy_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      loaded_q     <= 1'b0;
      wght_cnt_q   <= '0;
      fi_q         <= '0;
      ri_q         <= '0;
      row_cnt_q    <= '0;
      conv_first_q <= 1'b0;
      matx_q       <= '0;
      win_q        <= '0;
    end else begin
      conv_first_q <= (state_q != S_CONV) && (state_d == S_CONV);
      if (start_acc) begin
        row_cnt_q  <= '0;
        win_q      <= '0;
        wght_cnt_q <= '0;
        fi_q       <= '0;
        ri_q       <= '0;
      end
      if (wght_acc) begin
        matx_q[fi_q][ri_q] <= wght_data_i;
        if (wght_last) begin
          wght_cnt_q <= '0;
          fi_q       <= '0;
          ri_q       <= '0;
          loaded_q   <= 1'b1;
        end else begin
          wght_cnt_q <= wght_cnt_q + WCW'(1);
          if (ri_q == RW'(NUM_FILT_ROWS - 1)) begin
            ri_q <= '0;
            fi_q <= fi_q + FW'(1);
          end else begin
            ri_q <= ri_q + RW'(1);
          end
        end
      end
      if (row_acc) begin
        for (int i = 0; i < NUM_FILT_ROWS - 1; i++)
          win_q[i] <= win_q[i+1];
        win_q[NUM_FILT_ROWS-1] <= row_data_i;
        row_cnt_q <= row_cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_conv1_sched_ctrl.sv
// tb_conv1_sched_ctrl: randomized scoreboard bench for conv1_sched_ctrl.
// Frames are modelled as row lists; expected windows are queued per frame.
module tb_conv1_sched_ctrl;

  localparam int NF    = 24;
  localparam int NR    = 5;
  localparam int WB    = 40;
  localparam int DW    = 64;
  localparam int RPF   = 32;
  localparam int NW    = NF * NR;
  localparam int NCONV = RPF - NR + 1;

  logic clk = 1'b0;
  logic rst;
  logic start_m, start_p, start;
  logic reload;
  logic wv, wr, rv, rr;
  logic [WB-1:0] wd;
  logic [DW-1:0] rd;
  logic [NF-1:0][NR-1:0][WB-1:0] matx;
  logic [NR-1:0][DW-1:0] win;
  logic cs, done_p, done_h, done;
  logic [4:0] crow;
  logic busy, fd;

  assign start = start_m | start_p;
  assign done  = done_p | done_h;

  always #5 clk = ~clk;

  conv1_sched_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .wght_reload_i(reload),
    .wght_vld_i   (wv),
    .wght_data_i  (wd),
    .wght_rdy_o   (wr),
    .row_vld_i    (rv),
    .row_data_i   (rd),
    .row_rdy_o    (rr),
    .wght_matx_o  (matx),
    .row_win_o    (win),
    .conv_start_o (cs),
    .conv_done_i  (done),
    .conv_row_o   (crow),
    .busy_o       (busy),
    .frame_done_o (fd)
  );

  typedef struct {
    int                    row;
    logic [NR-1:0][DW-1:0] win;
  } exp_t;

  exp_t        expq[$];
  exp_t        me;
  logic [WB-1:0] wmodel [NF][NR];
  int vec    = 0;
  int mis    = 0;
  int frames = 0;
  int nconv  = 0;
  bit in_conv  = 0;
  bit exp_exit = 0;
  bit busy_chk = 0;
  bit spur_en  = 0;
  bit poke_en  = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    vec++;
    if (act !== req) begin
      mis++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic fail_to(input string nm);
    vec++;
    mis++;
    $display("FAIL %s: got timeout required event", nm);
  endtask

  task automatic chk_wmat(input string nm);
    int bf = -1;
    int br = -1;
    for (int f = 0; f < NF; f++)
      for (int r = 0; r < NR; r++)
        if (bf < 0 && matx[f][r] !== wmodel[f][r]) begin
          bf = f;
          br = r;
        end
    vec++;
    if (bf >= 0) begin
      mis++;
      $display("FAIL %s [%0d][%0d]: got %0h required %0h", nm, bf, br,
               matx[bf][br], wmodel[bf][br]);
    end
  endtask

  // Monitor: pops the scoreboard on every start pulse and checks the
  // MAC handshake rules cycle by cycle.
  always @(negedge clk) begin
    if (rst) begin
      in_conv  = 0;
      exp_exit = 0;
      busy_chk = 0;
      nconv    = 0;
    end else begin
      if (busy_chk) begin
        chk("busy_after_done", 64'(busy), 64'(0));
        busy_chk = 0;
      end
      if (exp_exit) begin
        chk("conv_exit", 64'(rr | fd), 64'(1));
        exp_exit = 0;
        in_conv  = 0;
      end else if (in_conv) begin
        chk("conv_hold", 64'({wr, rr, cs}), 64'(0));
      end
      if (cs) begin
        chk("start_rdy", 64'({wr, rr}), 64'(0));
        if (expq.size() == 0) begin
          vec++;
          mis++;
          $display("FAIL unexpected_start: got start required none");
        end else begin
          me = expq.pop_front();
          chk("conv_row", 64'(crow), 64'(me.row));
          for (int i = 0; i < NR; i++)
            chk($sformatf("win%0d_r%0d", i, me.row), win[i], me.win[i]);
          chk_wmat("wmat_at_start");
        end
        nconv++;
        in_conv = 1;
      end else if (in_conv && done) begin
        exp_exit = 1;
      end
      if (fd) begin
        chk("conv_count", 64'(nconv), 64'(NCONV));
        chk("expq_empty", 64'(expq.size()), 64'(0));
        chk("busy_in_done", 64'(busy), 64'(1));
        nconv    = 0;
        busy_chk = 1;
        frames++;
      end
    end
  end

  // MAC array model: random latency, optional stray done in the start
  // cycle and optional start pulse while converting.
  initial begin
    int d;
    done_p  = 0;
    start_p = 0;
    forever begin
      @(negedge clk);
      if (cs && !done_h && !rst) begin
        d = $urandom_range(0, 4);
        if (spur_en) done_p = 1;
        @(posedge clk); #1;
        done_p  = 0;
        start_p = poke_en;
        repeat (d) begin
          @(posedge clk); #1;
          start_p = 0;
        end
        done_p = 1;
        @(posedge clk); #1;
        done_p  = 0;
        start_p = 0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1);
  end

  task automatic do_reset();
    rst     = 1;
    wv      = 0;
    rv      = 0;
    start_m = 0;
    reload  = 0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 0;
    for (int f = 0; f < NF; f++)
      for (int r = 0; r < NR; r++)
        wmodel[f][r] = '0;
    expq.delete();
  endtask

  task automatic wait_rdy(input bit is_w, output bit ok);
    int t = 0;
    ok = 1;
    while ((is_w ? wr : rr) !== 1'b1) begin
      @(posedge clk); #1;
      t++;
      if (t > 400) begin
        fail_to(is_w ? "wght_rdy" : "row_rdy");
        ok = 0;
        return;
      end
    end
  endtask

  task automatic send_w(input logic [WB-1:0] d, input bit gaps,
                        output bit ok);
    if (gaps) begin
      wv = 0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    wv = 1;
    wd = d;
    wait_rdy(1, ok);
    @(posedge clk); #1;
    wv = 0;
  endtask

  task automatic send_r(input logic [DW-1:0] d, input bit gaps,
                        output bit ok);
    if (gaps) begin
      rv = 0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    rv = 1;
    rd = d;
    wait_rdy(0, ok);
    @(posedge clk); #1;
    rv = 0;
  endtask

  task automatic start_frame(input bit rl, input bit exp_load);
    start_m = 1;
    reload  = rl;
    @(posedge clk); #1;
    start_m = 0;
    reload  = 0;
    chk("busy_after_start", 64'(busy), 64'(1));
    chk("wrdy_after_start", 64'(wr), 64'(exp_load));
    chk("rrdy_after_start", 64'(rr), 64'(!exp_load));
  endtask

  task automatic run_frame(input bit rl, input bit exp_load,
                           input bit gaps, input bit seq);
    logic [DW-1:0] rows [RPF];
    logic [WB-1:0] nw [NF][NR];
    logic [63:0]   tmp;
    exp_t          e;
    bit            ok = 1;
    int            f0 = frames;
    int            t  = 0;
    start_frame(rl, exp_load);
    if (exp_load) begin
      for (int k = 0; k < NW; k++) begin
        tmp = {$urandom, $urandom};
        nw[k / NR][k % NR] = seq ? WB'(k) : tmp[WB-1:0];
      end
      for (int k = 0; k < NW && ok; k++)
        send_w(nw[k / NR][k % NR], gaps, ok);
      wmodel = nw;
    end
    for (int j = 0; j < RPF; j++)
      rows[j] = seq ? DW'(j) : {$urandom, $urandom};
    for (int j = 0; j < NCONV; j++) begin
      e.row = j;
      for (int i = 0; i < NR; i++) e.win[i] = rows[j + i];
      expq.push_back(e);
    end
    for (int j = 0; j < RPF && ok; j++)
      send_r(rows[j], gaps, ok);
    while (frames == f0 && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    if (frames == f0) begin
      fail_to("frame_done");
      do_reset();
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    bit          ok;
    logic [63:0] tmp;
    rst     = 1;
    start_m = 0;
    reload  = 0;
    wv      = 0;
    wd      = '0;
    rv      = 0;
    rd      = '0;
    done_h  = 0;
    do_reset();

    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_rdy", 64'({wr, rr}), 64'(0));
    chk("rst_start", 64'(cs), 64'(0));
    chk("rst_fdone", 64'(fd), 64'(0));
    chk("rst_crow", 64'(crow), 64'(0));
    for (int i = 0; i < NR; i++)
      chk($sformatf("rst_win%0d", i), win[i], 64'(0));
    chk_wmat("rst_wmat");

    run_frame(1, 1, 0, 1);
    chk("w23_4", 64'(matx[23][4]), 64'(119));
    chk("w0_0", 64'(matx[0][0]), 64'(0));
    chk("frames_a", 64'(frames), 64'(1));

    poke_en = 1;
    run_frame(0, 0, 1, 0);
    poke_en = 0;
    chk("w23_4_kept", 64'(matx[23][4]), 64'(119));

    done_h = 1;
    run_frame(1, 1, 1, 0);
    done_h = 0;

    spur_en = 1;
    run_frame(0, 0, 1, 0);
    spur_en = 0;

    start_frame(1, 1);
    ok = 1;
    for (int k = 0; k < 60 && ok; k++) begin
      tmp = {$urandom, $urandom};
      send_w(tmp[WB-1:0], 1, ok);
    end
    do_reset();
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_wrdy", 64'(wr), 64'(0));
    chk_wmat("midrst_wmat");

    run_frame(0, 1, 1, 0);
    run_frame(0, 0, 0, 0);
    chk("frames_total", 64'(frames), 64'(6));

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
